alu_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute/writeback controller for the highRISC datapath. It fetches instruction words from program memory over a request/acknowledge handshake, decodes them into the `eOperation`, immediate and register indices consumed by `ArithmeticLogicUnit`, and captures the ALU's `OutDest`/`OutFlags`. It then commits them to the register file and to the architectural flags register. It is the producer side of the ALU interface: it drives everything the ALU reads and consumes everything the ALU writes.

---
 rtl/alu_sequencer.sv | 153 +++++++++++++++
 tb/tb_alu_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback controller that feeds the highRISC ALU and
// commits its result to the register file and the architectural flags.

package InstructionSetPkg;
  localparam int DataWidth      = 16;
  localparam int ImmediateWidth = 8;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpSub  = 4'h1,
    OpAnd  = 4'h2,
    OpOr   = 4'h3,
    OpXor  = 4'h4,
    OpNand = 4'h5,
    OpRol  = 4'h6,
    OpRor  = 4'h7
  } eOperation;

  typedef struct packed {
    logic Carry;
    logic Zero;
    logic Negative;
    logic Overflow;
  } sFlags;
endpackage

module alu_sequencer
  import InstructionSetPkg::*;
#(
  parameter int         ProgAddrWidth = 8,
  parameter int         RegAddrWidth  = 3,
  parameter int         InstrWidth    = 24,
  parameter logic [3:0] HaltOpcode    = 4'hF
) (
  input  logic                      Clock,
  input  logic                      nReset,
  output logic [ProgAddrWidth-1:0]  ProgAddress,
  output logic                      FetchReq,
  input  logic                      FetchAck,
  input  logic [InstrWidth-1:0]     ProgData,
  output logic [RegAddrWidth-1:0]   SrcAddr,
  output logic [RegAddrWidth-1:0]   DestAddr,
  output eOperation                 Operation,
  output logic [ImmediateWidth-1:0] AluImm,
  output sFlags                     AluInFlags,
  input  sFlags                     AluOutFlags,
  input  logic [DataWidth-1:0]      AluResult,
  output logic                      RegWrEn,
  output logic [RegAddrWidth-1:0]   RegWrAddr,
  output logic [DataWidth-1:0]      RegWrData,
  output logic                      Halted
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    HALT      = 3'd5
  } state_e;

  localparam logic [ProgAddrWidth-1:0] PcStep = 1;

  state_e                      state;
  logic [ProgAddrWidth-1:0]    pc;
  logic [3:0]                  opcode;
  logic [RegAddrWidth-1:0]     rd;
  logic [RegAddrWidth-1:0]     rs;
  logic [ImmediateWidth-1:0]   imm;
  logic [DataWidth-1:0]        result;
  sFlags                       resultflags;
  sFlags                       flags;

  // The instruction register keeps only the decoded fields; the reserved bits are dropped.
  logic unused_reserved;
  assign unused_reserved = ^ProgData[13:8];

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state       <= IDLE;
      pc          <= '0;
      opcode      <= '0;
      rd          <= '0;
      rs          <= '0;
      imm         <= '0;
      result      <= '0;
      resultflags <= '0;
      flags       <= '0;
      FetchReq    <= 1'b0;
      RegWrEn     <= 1'b0;
      Halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state    <= FETCH;
          FetchReq <= 1'b1;
        end
        FETCH: begin
          if (FetchAck) begin
            opcode   <= ProgData[23:20];
            rd       <= ProgData[19:17];
            rs       <= ProgData[16:14];
            imm      <= ProgData[7:0];
            FetchReq <= 1'b0;
            if (ProgData[23:20] == HaltOpcode) begin
              state  <= HALT;
              Halted <= 1'b1;
            end else begin
              state  <= DECODE;
            end
          end
        end
        DECODE: begin
          state <= EXECUTE;
        end
        EXECUTE: begin
          result      <= AluResult;
          resultflags <= AluOutFlags;
          RegWrEn     <= 1'b1;
          state       <= WRITEBACK;
        end
        WRITEBACK: begin
          // Flags and PC commit together on the same edge that closes the write strobe.
          RegWrEn  <= 1'b0;
          flags    <= resultflags;
          pc       <= pc + PcStep;
          FetchReq <= 1'b1;
          state    <= FETCH;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state    <= IDLE;
          FetchReq <= 1'b0;
          RegWrEn  <= 1'b0;
          Halted   <= 1'b0;
        end
      endcase
    end
  end

  assign ProgAddress = pc;
  assign SrcAddr     = rs;
  assign DestAddr    = rd;
  assign Operation   = eOperation'(opcode);
  assign AluImm      = imm;
  assign AluInFlags  = flags;
  assign RegWrAddr   = rd;
  assign RegWrData   = result;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, corner-case sequences
// and a randomized run checked against a per-instruction reference model.

module tb_alu_sequencer;
  import InstructionSetPkg::*;

  logic        Clock;
  logic        nReset;
  logic [7:0]  ProgAddress;
  logic        FetchReq;
  logic        FetchAck;
  logic [23:0] ProgData;
  logic [2:0]  SrcAddr;
  logic [2:0]  DestAddr;
  eOperation   Operation;
  logic [7:0]  AluImm;
  sFlags       AluInFlags;
  sFlags       AluOutFlags;
  logic [15:0] AluResult;
  logic        RegWrEn;
  logic [2:0]  RegWrAddr;
  logic [15:0] RegWrData;
  logic        Halted;

  int checks = 0;
  int failures = 0;

  logic [7:0] mPc;
  logic [3:0] mFlags;

  alu_sequencer dut (
    .Clock(Clock), .nReset(nReset), .ProgAddress(ProgAddress), .FetchReq(FetchReq),
    .FetchAck(FetchAck), .ProgData(ProgData), .SrcAddr(SrcAddr), .DestAddr(DestAddr),
    .Operation(Operation), .AluImm(AluImm), .AluInFlags(AluInFlags),
    .AluOutFlags(AluOutFlags), .AluResult(AluResult), .RegWrEn(RegWrEn),
    .RegWrAddr(RegWrAddr), .RegWrData(RegWrData), .Halted(Halted)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  rd;
    logic [2:0]  rs;
    logic [7:0]  imm;
    int          waits;
    logic [15:0] res;
    logic [3:0]  outFlags;
    logic [7:0]  expPc;
    logic [3:0]  expFlags;
  } vec_t;

  vec_t vecs[5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Runs one instruction from its first FETCH cycle to the next FETCH cycle (or HALT).
  task automatic applyStimulus(input logic [23:0] word, input int waits,
                               input logic [15:0] res, input logic [3:0] outFlags,
                               input bit noise);
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] imm;
    op  = word[23:20];
    rd  = word[19:17];
    rs  = word[16:14];
    imm = word[7:0];
    checkOutput("fetch_req", 32'(FetchReq), 1);
    checkOutput("fetch_addr", 32'(ProgAddress), 32'(mPc));
    for (int w = 0; w < waits; w++) begin
      FetchAck = 1'b0;
      ProgData = 24'($urandom);
      @(posedge Clock); #1;
      checkOutput("wait_req", 32'(FetchReq), 1);
      checkOutput("wait_addr", 32'(ProgAddress), 32'(mPc));
      checkOutput("wait_wren", 32'(RegWrEn), 0);
    end
    FetchAck = 1'b1;
    ProgData = word;
    @(posedge Clock); #1;
    FetchAck = noise ? 1'($urandom) : 1'b0;
    ProgData = 24'($urandom);
    if (op == 4'hF) begin
      checkOutput("halt_flag", 32'(Halted), 1);
      checkOutput("halt_req", 32'(FetchReq), 0);
      checkOutput("halt_addr", 32'(ProgAddress), 32'(mPc));
      return;
    end
    AluResult   = ~res;
    AluOutFlags = ~outFlags;
    checkOutput("dec_req", 32'(FetchReq), 0);
    checkOutput("dec_op", 32'(Operation), 32'(op));
    checkOutput("dec_src", 32'(SrcAddr), 32'(rs));
    checkOutput("dec_dst", 32'(DestAddr), 32'(rd));
    checkOutput("dec_imm", 32'(AluImm), 32'(imm));
    checkOutput("dec_wren", 32'(RegWrEn), 0);
    @(posedge Clock); #1;
    AluResult   = res;
    AluOutFlags = outFlags;
    FetchAck    = noise ? 1'($urandom) : 1'b0;
    checkOutput("exe_op", 32'(Operation), 32'(op));
    checkOutput("exe_inflags", 32'(AluInFlags), 32'(mFlags));
    checkOutput("exe_wren", 32'(RegWrEn), 0);
    @(posedge Clock); #1;
    AluResult   = 16'($urandom);
    AluOutFlags = 4'($urandom);
    FetchAck    = noise ? 1'($urandom) : 1'b0;
    checkOutput("wb_wren", 32'(RegWrEn), 1);
    checkOutput("wb_addr", 32'(RegWrAddr), 32'(rd));
    checkOutput("wb_data", 32'(RegWrData), 32'(res));
    checkOutput("wb_inflags_old", 32'(AluInFlags), 32'(mFlags));
    @(posedge Clock); #1;
    FetchAck = 1'b0;
    mPc    = mPc + 8'd1;
    mFlags = outFlags;
    checkOutput("post_wren", 32'(RegWrEn), 0);
    checkOutput("post_inflags", 32'(AluInFlags), 32'(mFlags));
    checkOutput("post_req", 32'(FetchReq), 1);
    checkOutput("post_addr", 32'(ProgAddress), 32'(mPc));
  endtask

  task automatic releaseReset();
    @(posedge Clock); #1;
    nReset = 1'b1;
    #1;
    checkOutput("rel_c1_req", 32'(FetchReq), 0);
    checkOutput("rel_c1_halted", 32'(Halted), 0);
    @(posedge Clock); #1;
    checkOutput("rel_c2_req", 32'(FetchReq), 1);
    checkOutput("rel_c2_addr", 32'(ProgAddress), 0);
    checkOutput("rel_c2_inflags", 32'(AluInFlags), 0);
    mPc    = 8'h00;
    mFlags = 4'h0;
  endtask

  task automatic doReset();
    nReset = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      checkOutput("rst_req", 32'(FetchReq), 0);
      checkOutput("rst_wren", 32'(RegWrEn), 0);
      checkOutput("rst_halted", 32'(Halted), 0);
      checkOutput("rst_addr", 32'(ProgAddress), 0);
      checkOutput("rst_wrdata", 32'(RegWrData), 0);
      checkOutput("rst_wraddr", 32'(RegWrAddr), 0);
      checkOutput("rst_inflags", 32'(AluInFlags), 0);
      @(posedge Clock); #1;
    end
    releaseReset();
  endtask

  initial begin
    nReset      = 1'b0;
    FetchAck    = 1'b0;
    ProgData    = '0;
    AluResult   = '0;
    AluOutFlags = '0;
    mPc         = '0;
    mFlags      = '0;

    vecs[0] = '{4'h5, 3'd2, 3'd1, 8'h00, 0, 16'h00FF, 4'b0000, 8'h01, 4'b0000};
    vecs[1] = '{4'h6, 3'd3, 3'd2, 8'h81, 3, 16'h0003, 4'b1000, 8'h02, 4'b1000};
    vecs[2] = '{4'h0, 3'd7, 3'd7, 8'h7F, 1, 16'h0000, 4'b0100, 8'h03, 4'b0100};
    vecs[3] = '{4'hC, 3'd1, 3'd6, 8'h33, 0, 16'h0000, 4'b0100, 8'h04, 4'b0100};
    vecs[4] = '{4'h7, 3'd0, 3'd5, 8'hFE, 2, 16'h8000, 4'b0010, 8'h05, 4'b0010};

    doReset();

    // Abort mid-WRITEBACK: no commit, fetch restarts at PC 0.
    FetchAck = 1'b1;
    ProgData = {4'h0, 3'd3, 3'd4, 6'd0, 8'h12};
    @(posedge Clock); #1;
    FetchAck    = 1'b0;
    AluResult   = 16'hBEEF;
    AluOutFlags = 4'hF;
    @(posedge Clock); #1;
    @(posedge Clock); #1;
    checkOutput("midop_wren_set", 32'(RegWrEn), 1);
    #2 nReset = 1'b0;
    #1;
    checkOutput("midop_wren_drop", 32'(RegWrEn), 0);
    checkOutput("midop_req", 32'(FetchReq), 0);
    checkOutput("midop_flags", 32'(AluInFlags), 0);
    checkOutput("midop_addr", 32'(ProgAddress), 0);
    @(posedge Clock); #1;
    checkOutput("midop_flags_held", 32'(AluInFlags), 0);
    releaseReset();

    for (int i = 0; i < 5; i++) begin
      applyStimulus({vecs[i].op, vecs[i].rd, vecs[i].rs, 6'd0, vecs[i].imm},
                    vecs[i].waits, vecs[i].res, vecs[i].outFlags, 1'b0);
      checkOutput("vec_pc", 32'(ProgAddress), 32'(vecs[i].expPc));
      checkOutput("vec_flags", 32'(AluInFlags), 32'(vecs[i].expFlags));
    end

    // HALT at PC 5: nothing issues and the PC stays on the HALT word.
    applyStimulus({4'hF, 3'd1, 3'd1, 6'd0, 8'h00}, 1, 16'h1234, 4'hF, 1'b0);
    for (int c = 0; c < 20; c++) begin
      FetchAck = 1'b1;
      ProgData = 24'($urandom);
      @(posedge Clock); #1;
      checkOutput("halt_hold_req", 32'(FetchReq), 0);
      checkOutput("halt_hold_addr", 32'(ProgAddress), 5);
      checkOutput("halt_hold_flag", 32'(Halted), 1);
      checkOutput("halt_hold_wren", 32'(RegWrEn), 0);
    end
    FetchAck = 1'b0;
    doReset();

    // Random program until the PC reaches 8'hFF, then ROR wraps it to 8'h00.
    for (int i = 0; i < 255; i++) begin
      applyStimulus({4'($urandom_range(0, 14)), 3'($urandom), 3'($urandom), 6'($urandom), 8'($urandom)},
                    $urandom_range(0, 2), 16'($urandom), 4'($urandom), 1'b1);
    end
    checkOutput("pre_wrap_pc", 32'(ProgAddress), 32'hFF);
    applyStimulus({4'h7, 3'd4, 3'd2, 6'd0, 8'h01}, 0, 16'h4001, 4'b1000, 1'b0);
    checkOutput("wrap_pc", 32'(ProgAddress), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
